// File: rtl/pcie_pkg.sv
// Shared definitions for the transaction-layer flow-control block:
// link state encoding, word field positions and default threshold widths.
package pcie_pkg;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

    localparam int VC_BIT   = 5;
    localparam int DEST_BIT = 4;
    localparam int DATA_W   = 4;

    localparam int MF_UW_D = 2;
    localparam int VC_UW_D = 4;
    localparam int D_UW_D  = 2;

endpackage

// File: rtl/pcie_vc_arbiter.sv
// Combinational pop generation for MF->VC and VC->D with VC0 priority
// and almost-full backpressure on the selected destination FIFO.
module pcie_vc_arbiter
    import pcie_pkg::*;
(
    input  logic i_en,
    input  logic i_empty_MF,
    input  logic i_empty_VC0,
    input  logic i_empty_VC1,
    input  logic i_afull_VC0,
    input  logic i_afull_VC1,
    input  logic i_afull_D0,
    input  logic i_afull_D1,
    input  logic i_mf_head_vc,
    input  logic i_vc0_head_dest,
    input  logic i_vc1_head_dest,
    output logic o_pop_MF,
    output logic o_pop_VC0,
    output logic o_pop_VC1
);

    logic w_mf_blk;
    logic w_vc0_blk;
    logic w_vc1_blk;
    logic w_same_dest;

    assign w_mf_blk    = i_mf_head_vc ? i_afull_VC1 : i_afull_VC0;
    assign w_vc0_blk   = i_vc0_head_dest ? i_afull_D1 : i_afull_D0;
    assign w_vc1_blk   = i_vc1_head_dest ? i_afull_D1 : i_afull_D0;
    assign w_same_dest = (i_vc0_head_dest == i_vc1_head_dest);

    assign o_pop_MF  = i_en & ~i_empty_MF & ~w_mf_blk;
    assign o_pop_VC0 = i_en & ~i_empty_VC0 & ~w_vc0_blk;
    // VC1 only shares the cycle with VC0 when heading to the other D FIFO
    assign o_pop_VC1 = i_en & ~i_empty_VC1 & ~w_vc1_blk
                     & ~(o_pop_VC0 & w_same_dest);

endmodule

// File: rtl/pcie_flow_ctrl.sv
// Link state machine, threshold latching and internal pop arbitration
// for the MF -> VC0/VC1 -> D0/D1 FIFO datapath.
module pcie_flow_ctrl
    import pcie_pkg::*;
#(
    parameter int MF_UW = MF_UW_D,
    parameter int VC_UW = VC_UW_D,
    parameter int D_UW  = D_UW_D
) (
    input  logic             clk,
    input  logic             reset_L,
    input  logic             init,
    input  logic [MF_UW-1:0] umbral_MF,
    input  logic [VC_UW-1:0] umbral_VC0,
    input  logic [VC_UW-1:0] umbral_VC1,
    input  logic [D_UW-1:0]  umbral_D0,
    input  logic [D_UW-1:0]  umbral_D1,
    input  logic             push,
    input  logic             pop_D0,
    input  logic             pop_D1,
    input  logic             empty_MF,
    input  logic             full_MF,
    input  logic             empty_VC0,
    input  logic             empty_VC1,
    input  logic             empty_D0,
    input  logic             empty_D1,
    input  logic             full_D0,
    input  logic             full_D1,
    input  logic             afull_VC0,
    input  logic             afull_VC1,
    input  logic             afull_D0,
    input  logic             afull_D1,
    input  logic             mf_head_vc,
    input  logic             vc0_head_dest,
    input  logic             vc1_head_dest,
    output logic             pop_MF,
    output logic             pop_VC0,
    output logic             pop_VC1,
    output logic [MF_UW-1:0] umbral_MF_o,
    output logic [VC_UW-1:0] umbral_VC0_o,
    output logic [VC_UW-1:0] umbral_VC1_o,
    output logic [D_UW-1:0]  umbral_D0_o,
    output logic [D_UW-1:0]  umbral_D1_o,
    output logic             active_out,
    output logic             idle_out,
    output logic             error_out,
    output logic [2:0]       state
);

    state_e r_state;
    state_e w_next;
    logic   w_err;
    logic   w_all_empty;
    logic   w_en;
    logic   w_unused;

    assign w_err = (push & full_MF)
                 | (pop_D0 & empty_D0)
                 | (pop_D1 & empty_D1);

    assign w_all_empty = empty_MF & empty_VC0 & empty_VC1
                       & empty_D0 & empty_D1;

    // D full flags are observed through afull; nothing else needs them
    assign w_unused = ^{full_D0, full_D1};

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_RESET:  w_next = ST_INIT;
            ST_INIT:   w_next = init ? ST_INIT : ST_IDLE;
            ST_IDLE: begin
                if (w_err)             w_next = ST_ERROR;
                else if (init)         w_next = ST_INIT;
                else if (!w_all_empty) w_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (w_err)            w_next = ST_ERROR;
                else if (init)        w_next = ST_INIT;
                else if (w_all_empty) w_next = ST_IDLE;
            end
            ST_ERROR:  w_next = init ? ST_INIT : ST_ERROR;
            default:   w_next = ST_RESET;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state      <= ST_RESET;
            umbral_MF_o  <= '0;
            umbral_VC0_o <= '0;
            umbral_VC1_o <= '0;
            umbral_D0_o  <= '0;
            umbral_D1_o  <= '0;
            idle_out     <= 1'b0;
            active_out   <= 1'b0;
            error_out    <= 1'b0;
        end else begin
            r_state    <= w_next;
            idle_out   <= (w_next == ST_IDLE);
            active_out <= (w_next == ST_ACTIVE);
            error_out  <= (w_next == ST_ERROR);
            if (r_state == ST_INIT) begin
                umbral_MF_o  <= umbral_MF;
                umbral_VC0_o <= umbral_VC0;
                umbral_VC1_o <= umbral_VC1;
                umbral_D0_o  <= umbral_D0;
                umbral_D1_o  <= umbral_D1;
            end
        end
    end

    assign state = r_state;

    // reset_L gates pops combinationally so they drop before the edge
    assign w_en = reset_L
                & ((r_state == ST_IDLE) | (r_state == ST_ACTIVE));

    pcie_vc_arbiter u_arb (
        .i_en            (w_en),
        .i_empty_MF      (empty_MF),
        .i_empty_VC0     (empty_VC0),
        .i_empty_VC1     (empty_VC1),
        .i_afull_VC0     (afull_VC0),
        .i_afull_VC1     (afull_VC1),
        .i_afull_D0      (afull_D0),
        .i_afull_D1      (afull_D1),
        .i_mf_head_vc    (mf_head_vc),
        .i_vc0_head_dest (vc0_head_dest),
        .i_vc1_head_dest (vc1_head_dest),
        .o_pop_MF        (pop_MF),
        .o_pop_VC0       (pop_VC0),
        .o_pop_VC1       (pop_VC1)
    );

endmodule

// File: tb/tb_pcie_flow_ctrl.sv
// Directed bench for pcie_flow_ctrl: arbitration vector table plus
// hand-written FSM sequences (reset, init, error, mid-traffic reset).
module tb_pcie_flow_ctrl;

    logic       clk = 1'b0;
    logic       reset_L, init, push, pop_D0, pop_D1;
    logic [1:0] umbral_MF, umbral_D0, umbral_D1;
    logic [3:0] umbral_VC0, umbral_VC1;
    logic       empty_MF, full_MF, empty_VC0, empty_VC1;
    logic       empty_D0, empty_D1, full_D0, full_D1;
    logic       afull_VC0, afull_VC1, afull_D0, afull_D1;
    logic       mf_head_vc, vc0_head_dest, vc1_head_dest;
    logic       pop_MF, pop_VC0, pop_VC1;
    logic [1:0] umbral_MF_o, umbral_D0_o, umbral_D1_o;
    logic [3:0] umbral_VC0_o, umbral_VC1_o;
    logic       active_out, idle_out, error_out;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pcie_flow_ctrl dut (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_MF(umbral_MF), .umbral_VC0(umbral_VC0),
        .umbral_VC1(umbral_VC1), .umbral_D0(umbral_D0),
        .umbral_D1(umbral_D1), .push(push),
        .pop_D0(pop_D0), .pop_D1(pop_D1),
        .empty_MF(empty_MF), .full_MF(full_MF),
        .empty_VC0(empty_VC0), .empty_VC1(empty_VC1),
        .empty_D0(empty_D0), .empty_D1(empty_D1),
        .full_D0(full_D0), .full_D1(full_D1),
        .afull_VC0(afull_VC0), .afull_VC1(afull_VC1),
        .afull_D0(afull_D0), .afull_D1(afull_D1),
        .mf_head_vc(mf_head_vc), .vc0_head_dest(vc0_head_dest),
        .vc1_head_dest(vc1_head_dest),
        .pop_MF(pop_MF), .pop_VC0(pop_VC0), .pop_VC1(pop_VC1),
        .umbral_MF_o(umbral_MF_o), .umbral_VC0_o(umbral_VC0_o),
        .umbral_VC1_o(umbral_VC1_o), .umbral_D0_o(umbral_D0_o),
        .umbral_D1_o(umbral_D1_o),
        .active_out(active_out), .idle_out(idle_out),
        .error_out(error_out), .state(state)
    );

    typedef struct packed {
        logic e_mf, e_v0, e_v1;
        logic mvc, d0, d1;
        logic af_v0, af_v1, af_d0, af_d1;
        logic x_mf, x_v0, x_v1;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string nm, input int st,
                          input int i, input int a, input int e);
        chk({nm, ".state"}, int'(state), st);
        chk({nm, ".idle"}, int'(idle_out), i);
        chk({nm, ".active"}, int'(active_out), a);
        chk({nm, ".error"}, int'(error_out), e);
    endtask

    task automatic chk_pops(input string nm, input int m,
                            input int v0, input int v1);
        chk({nm, ".pop_MF"}, int'(pop_MF), m);
        chk({nm, ".pop_VC0"}, int'(pop_VC0), v0);
        chk({nm, ".pop_VC1"}, int'(pop_VC1), v1);
    endtask

    initial begin
        //         eMF eV0 eV1 mvc d0 d1 aV0 aV1 aD0 aD1  MF V0 V1
        vt[0]  = {1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
        vt[1]  = {1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vt[2]  = {1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0};
        vt[3]  = {1'b0,1'b1,1'b1, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0};
        vt[4]  = {1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
        vt[5]  = {1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b1};
        vt[6]  = {1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1};
        vt[7]  = {1'b1,1'b1,1'b0, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1};
        vt[8]  = {1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0};
        vt[9]  = {1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b1,1'b0};
        vt[10] = {1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,1'b0, 1'b0,1'b1,1'b0};
        vt[11] = {1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0};

        reset_L = 0; init = 0; push = 0; pop_D0 = 0; pop_D1 = 0;
        umbral_MF = 0; umbral_VC0 = 0; umbral_VC1 = 0;
        umbral_D0 = 0; umbral_D1 = 0;
        empty_MF = 1; full_MF = 0; empty_VC0 = 1; empty_VC1 = 1;
        empty_D0 = 1; empty_D1 = 1; full_D0 = 0; full_D1 = 0;
        afull_VC0 = 0; afull_VC1 = 0; afull_D0 = 0; afull_D1 = 0;
        mf_head_vc = 0; vc0_head_dest = 0; vc1_head_dest = 0;

        step();
        chk_st("rst", 0, 0, 0, 0);
        chk("rst.umbral_VC0_o", int'(umbral_VC0_o), 0);
        empty_MF = 0;
        #1;
        chk("rst.pop_MF", int'(pop_MF), 0);
        empty_MF = 1;

        reset_L = 1; init = 1;
        umbral_MF = 2'h2; umbral_VC0 = 4'h3; umbral_VC1 = 4'h5;
        umbral_D0 = 2'h1; umbral_D1 = 2'h3;
        step();
        chk_st("init", 1, 0, 0, 0);
        chk("init.umbral_VC0_o", int'(umbral_VC0_o), 0);
        init = 0; empty_MF = 0;
        #1;
        chk("init.pop_MF", int'(pop_MF), 0);
        step();
        chk_st("idle", 2, 1, 0, 0);
        chk("idle.umbral_MF_o", int'(umbral_MF_o), 2);
        chk("idle.umbral_VC0_o", int'(umbral_VC0_o), 3);
        chk("idle.umbral_VC1_o", int'(umbral_VC1_o), 5);
        chk("idle.umbral_D0_o", int'(umbral_D0_o), 1);
        chk("idle.umbral_D1_o", int'(umbral_D1_o), 3);
        chk("idle.pop_MF", int'(pop_MF), 1);
        umbral_VC0 = 4'h9;
        step();
        chk_st("active", 3, 0, 1, 0);
        chk("active.umbral_held", int'(umbral_VC0_o), 3);

        for (int i = 0; i < 12; i++) begin
            empty_MF = vt[i].e_mf; empty_VC0 = vt[i].e_v0;
            empty_VC1 = vt[i].e_v1; mf_head_vc = vt[i].mvc;
            vc0_head_dest = vt[i].d0; vc1_head_dest = vt[i].d1;
            afull_VC0 = vt[i].af_v0; afull_VC1 = vt[i].af_v1;
            afull_D0 = vt[i].af_d0; afull_D1 = vt[i].af_d1;
            #1;
            chk_pops($sformatf("vec%0d", i), int'(vt[i].x_mf),
                     int'(vt[i].x_v0), int'(vt[i].x_v1));
            step();
        end
        chk_st("back_idle", 2, 1, 0, 0);

        empty_MF = 0; afull_VC0 = 0;
        step();
        chk_st("err.pre", 3, 0, 1, 0);
        push = 1; full_MF = 1;
        step();
        chk_st("err.ovf", 4, 0, 0, 1);
        #1;
        chk("err.pop_MF", int'(pop_MF), 0);
        push = 0; full_MF = 0;
        step();
        chk_st("err.sticky", 4, 0, 0, 1);
        chk("err.umbral_held", int'(umbral_VC0_o), 3);
        init = 1;
        step();
        chk_st("err.init", 1, 0, 0, 0);
        push = 1; full_MF = 1;
        step();
        chk_st("init.err_ign", 1, 0, 0, 0);
        push = 0; full_MF = 0; init = 0; empty_MF = 1;
        step();
        chk_st("idle2", 2, 1, 0, 0);
        chk("idle2.umbral_VC0_o", int'(umbral_VC0_o), 9);

        pop_D1 = 1;
        step();
        chk_st("undf", 4, 0, 0, 1);
        pop_D1 = 0; init = 1;
        step();
        init = 0; empty_MF = 0;
        step();
        chk_st("idle3", 2, 1, 0, 0);
        step();
        chk_st("active3", 3, 0, 1, 0);
        init = 1;
        #1;
        chk("act_init.pop_MF_same", int'(pop_MF), 1);
        step();
        chk_st("act_init", 1, 0, 0, 0);
        chk("act_init.pop_MF", int'(pop_MF), 0);
        init = 0;
        step();
        step();
        chk_st("active4", 3, 0, 1, 0);
        chk("active4.pop_MF", int'(pop_MF), 1);
        reset_L = 0;
        #1;
        chk("midrst.pop_MF", int'(pop_MF), 0);
        step();
        chk_st("midrst", 0, 0, 0, 0);
        chk("midrst.umbral_MF_o", int'(umbral_MF_o), 0);
        chk("midrst.umbral_VC0_o", int'(umbral_VC0_o), 0);
        chk("midrst.umbral_VC1_o", int'(umbral_VC1_o), 0);
        chk("midrst.umbral_D0_o", int'(umbral_D0_o), 0);
        chk("midrst.umbral_D1_o", int'(umbral_D1_o), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcie_flow_ctrl.md
Name: pcie_flow_ctrl

Overview:
Control and arbitration block for the transaction-layer FIFO datapath: main FIFO (MF) -> VC0/VC1 FIFOs -> D0/D1 FIFOs, word = {vc[5], dest[4], data[3:0]}.
- Runs the link state machine (RESET/INIT/IDLE/ACTIVE/ERROR).
- Latches and distributes the FIFO threshold (umbral) configuration.
- Generates the internal pops MF->VC and VC->D, with VC0-priority arbitration and almost-full backpressure.

Parameters:
- MF_UW, 2, width of umbral_MF
- VC_UW, 4, width of umbral_VC0/umbral_VC1
- D_UW, 2, width of umbral_D0/umbral_D1

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset_L  in  1  synchronous reset, active-low
- init  in  1  request configuration; thresholds are sampled while in INIT
- umbral_MF / umbral_VC0 / umbral_VC1 / umbral_D0 / umbral_D1  in  MF_UW/VC_UW/VC_UW/D_UW/D_UW  threshold configuration inputs
- push  in  1  external push into MF (monitored for overflow)
- pop_D0, pop_D1  in  1  external pops of D0/D1 (monitored for underflow)
- empty_MF, full_MF, empty_VC0, empty_VC1, empty_D0, empty_D1, full_D0, full_D1  in  1  FIFO status
- afull_VC0, afull_VC1, afull_D0, afull_D1  in  1  almost-full flags (FIFO count >= programmed umbral)
- mf_head_vc  in  1  bit 5 of the MF head word
- vc0_head_dest, vc1_head_dest  in  1  bit 4 of the VC0/VC1 head words
- pop_MF, pop_VC0, pop_VC1  out  1  internal pops (combinational)
- umbral_MF_o, umbral_VC0_o, umbral_VC1_o, umbral_D0_o, umbral_D1_o  out  as inputs  registered thresholds driven to the FIFOs
- active_out, idle_out, error_out  out  1  registered state flags
- state  out  3  encoded state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- Reset: reset_L=0 at a rising edge puts the block in state RESET. All umbral_*_o=0 and all flags=0. Pops are forced to 0 while reset_L=0 or state is RESET, INIT or ERROR.
- err_cond = (push & full_MF) | (pop_D0 & empty_D0) | (pop_D1 & empty_D1).
- all_empty = empty_MF & empty_VC0 & empty_VC1 & empty_D0 & empty_D1.
- Transitions, evaluated at each rising edge in priority order: reset_L=0 > err_cond > init > remaining conditions.
  - RESET -> INIT unconditionally once reset_L=1.
  - INIT: umbral_*_o <= umbral_* every cycle. Stays in INIT while init=1; -> IDLE when init=0. err_cond is ignored in INIT.
  - IDLE: err_cond -> ERROR; init -> INIT; !all_empty -> ACTIVE; else stay.
  - ACTIVE: err_cond -> ERROR; init -> INIT; all_empty -> IDLE; else stay.
  - ERROR: sticky. Only init (-> INIT) or reset_L=0 leaves it. umbral_*_o are held.
- Flags are Moore outputs from the state register:
  - idle_out = (state==IDLE), active_out = (state==ACTIVE), error_out = (state==ERROR).
  - Each flag updates 1 cycle after the triggering condition.
- Pops: en = (state==IDLE | state==ACTIVE) & reset_L. Pop signals are combinational; the FIFO updates at the next edge.
  - pop_MF = en & !empty_MF & !(mf_head_vc ? afull_VC1 : afull_VC0).
  - pop_VC0 = en & !empty_VC0 & !(vc0_head_dest ? afull_D1 : afull_D0).
  - pop_VC1 = en & !empty_VC1 & !(vc1_head_dest ? afull_D1 : afull_D0) & !(pop_VC0 & vc0_head_dest==vc1_head_dest).
  - VC0 and VC1 may pop in the same cycle only if their destinations differ. VC1 wins when VC0 is blocked or empty.
- umbral_*_o change only in INIT. No change occurs mid-traffic without passing through INIT.
- Reset in mid-operation: pops drop in the same cycle reset_L goes low. State returns to RESET at the next edge.
- init asserted during ACTIVE moves the block to INIT; pops stop from that cycle on.

Decomposition:
- Shared package pcie_pkg: state encoding constants (RESET..ERROR), word field positions (VC_BIT=5, DEST_BIT=4, DATA_W=4) and the default umbral widths.
- Natural sub-module: pcie_vc_arbiter, the combinational pop/priority logic. It takes en, empty, afull and head bits and returns pop_MF/VC0/VC1.
- The FSM and threshold registers stay in the top block.

Test Plan:
- Reset/init sequence: reset_L=0 for 1 cycle, then 1. init=1 for 1 cycle with umbral_VC0=4'h3, umbral_D0=2'h1 -> state goes RESET, INIT, IDLE. umbral_VC0_o=3 and umbral_D0_o=1 one cycle after INIT. idle_out=1.
- Traffic: in IDLE set empty_MF=0, mf_head_vc=0, afull_VC0=0 -> pop_MF=1 in the same cycle. Next edge: state=ACTIVE, active_out=1. Set all empties=1 -> back to IDLE 1 cycle later.
- Arbitration conflict: empty_VC0=0, empty_VC1=0, both head_dest=0, afull_D0=0 -> pop_VC0=1, pop_VC1=0.
- Parallel and blocked pops: with vc1_head_dest=1 -> both pop. With afull_D0=1 and vc1_head_dest=1 -> pop_VC0=0, pop_VC1=1.
- Error: in ACTIVE drive push=1, full_MF=1 -> state=ERROR, error_out=1 next cycle, all pops 0. err_cond deasserted -> still ERROR. init=1 -> INIT.
- Underflow and mid-operation reset: pop_D1=1 with empty_D1=1 in IDLE -> ERROR. reset_L=0 while ACTIVE with pop_MF=1 -> pop_MF=0 immediately, state=RESET next edge, all umbral_*_o=0.
